// File: rtl/even_bcd_counter_pkg.sv
// Shared types and the BCD step rule for the even-only two-digit counter.
package even_cnt_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_ONES = 4'd8;
  localparam bcd_t BCD_MAX_TENS = 4'd9;

  typedef struct packed {
    logic wrap;
    bcd_t tens;
    bcd_t ones;
  } bcd_count_t;

  // Range compares (>=, <) keep the digits legal even from an unexpected value.
  function automatic bcd_count_t bcdAdvance(input bcd_t tens, input bcd_t ones, input logic down);
    bcd_count_t res;
    res.wrap = 1'b0;
    res.tens = tens;
    res.ones = ones;
    if (!down) begin
      if (ones >= BCD_MAX_ONES) begin
        res.ones = 4'd0;
        if (tens >= BCD_MAX_TENS) begin
          res.tens = 4'd0;
          res.wrap = 1'b1;
        end else begin
          res.tens = tens + 4'd1;
        end
      end else begin
        res.ones = ones + 4'd2;
      end
    end else begin
      if (ones < 4'd2) begin
        res.ones = BCD_MAX_ONES;
        if (tens == 4'd0) begin
          res.tens = BCD_MAX_TENS;
          res.wrap = 1'b1;
        end else begin
          res.tens = tens - 4'd1;
        end
      end else begin
        res.ones = ones - 4'd2;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/even_bcd_counter_if.sv
// Switch/button inputs and digit/status outputs of the even BCD counter.
interface even_bcd_counter_if;
  import even_cnt_pkg::*;

  logic run_sw;
  logic dir_sw;
  logic step_n;
  logic clear_n;
  bcd_t ones;
  bcd_t tens;
  logic wrap;
  logic running;

  modport master (output run_sw, dir_sw, step_n, clear_n,
                  input  ones, tens, wrap, running);

  modport slave  (input  run_sw, dir_sw, step_n, clear_n,
                  output ones, tens, wrap, running);

endinterface

// File: rtl/even_bcd_counter_sync_edge.sv
// Two-flop synchronizer for an active-low button with a one-cycle press pulse.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_syncDly;
  logic r_live;
  logic r_armed;

  // Arming waits for a real high sample so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_syncDly <= 1'b1;
      r_live    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_meta    <= i_async_n;
      r_sync    <= r_meta;
      r_syncDly <= r_sync;
      r_live    <= 1'b1;
      if (r_live && r_meta) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_fall = r_armed & r_syncDly & ~r_sync;

endmodule

// File: rtl/even_bcd_counter.sv
// Two-digit even BCD counter: free-runs off a prescaler in RUN, steps by button in IDLE.
module even_bcd_counter
  import even_cnt_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic               clk,
  input logic               reset_n,
  even_bcd_counter_if.slave bus
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  logic          r_runMeta;
  logic          r_runSync;
  logic          r_dirMeta;
  logic          r_dirSync;
  logic          w_stepPulse;
  logic          w_clearPulse;
  state_t        r_state;
  state_t        w_nextState;
  logic [PW-1:0] r_prescale;
  logic          w_tick;
  logic          w_advance;
  bcd_count_t    w_stepped;
  bcd_t          r_ones;
  bcd_t          r_tens;
  logic          r_wrap;
  logic          r_running;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_runMeta <= 1'b0;
      r_runSync <= 1'b0;
      r_dirMeta <= 1'b0;
      r_dirSync <= 1'b0;
    end else begin
      r_runMeta <= bus.run_sw;
      r_runSync <= r_runMeta;
      r_dirMeta <= bus.dir_sw;
      r_dirSync <= r_dirMeta;
    end
  end

  sync_edge u_stepSync (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_async_n (bus.step_n),
    .o_fall    (w_stepPulse)
  );

  sync_edge u_clearSync (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_async_n (bus.clear_n),
    .o_fall    (w_clearPulse)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_runSync)  w_nextState = RUN;
      RUN:     if (!r_runSync) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_running <= (w_nextState == RUN);
    end
  end

  assign w_tick    = (r_state == RUN) && (r_prescale == TICK_LAST);
  assign w_advance = w_tick || ((r_state == IDLE) && w_stepPulse);
  assign w_stepped = bcdAdvance(r_tens, r_ones, r_dirSync);

  // Holding at zero through IDLE means RUN always starts a full period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prescale <= '0;
    end else if ((r_state != RUN) || w_clearPulse || w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_clearPulse) begin
        r_ones <= 4'd0;
        r_tens <= 4'd0;
      end else if (w_advance) begin
        r_ones <= w_stepped.ones;
        r_tens <= w_stepped.tens;
        r_wrap <= w_stepped.wrap;
      end
    end
  end

  assign bus.ones    = r_ones;
  assign bus.tens    = r_tens;
  assign bus.wrap    = r_wrap;
  assign bus.running = r_running;

endmodule

// File: tb/tb_even_bcd_counter.sv
// Directed bench for even_bcd_counter with TICK_DIV=4; expected counts are hand-derived BCD constants.
module tb_even_bcd_counter;
  import even_cnt_pkg::*;

  localparam int TICK_DIV = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [7:0] upTable [10] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h10,
                               8'h12, 8'h14, 8'h16, 8'h18, 8'h20};

  even_bcd_counter_if bus ();

  even_bcd_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] countBcd();
    return {bus.tens, bus.ones};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic dir, input logic stepN, input logic clearN);
    bus.run_sw  = run;
    bus.dir_sw  = dir;
    bus.step_n  = stepN;
    bus.clear_n = clearN;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One IDLE press: result lands on the third edge, wrap must drop the cycle after.
  task automatic stepPress(input logic dir, input logic [7:0] expCount, input logic expWrap, input string tag);
    applyStimulus(1'b0, dir, 1'b0, 1'b1);
    waitCycles(3);
    checkOutput({tag, "_count"}, 32'(countBcd()), 32'(expCount));
    checkOutput({tag, "_wrap"}, 32'(bus.wrap), 32'(expWrap));
    applyStimulus(1'b0, dir, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput({tag, "_wrapDrop"}, 32'(bus.wrap), 32'(0));
    waitCycles(2);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("reset_count", 32'(countBcd()), 32'(8'h00));
    checkOutput("reset_wrap", 32'(bus.wrap), 32'(0));
    checkOutput("reset_running", 32'(bus.running), 32'(0));
    reset_n = 1'b1;
    waitCycles(3);

    for (int i = 0; i < 10; i++) begin
      stepPress(1'b0, upTable[i], 1'b0, $sformatf("up%0d", i));
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(3);
    stepPress(1'b1, 8'h18, 1'b0, "downBorrow");

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput("clearIdle_count", 32'(countBcd()), 32'(8'h00));
    checkOutput("clearIdle_wrap", 32'(bus.wrap), 32'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(3);

    stepPress(1'b1, 8'h98, 1'b1, "downWrap");
    stepPress(1'b1, 8'h96, 1'b0, "down96");

    // Free-run up from 96: entry at edge 3, advances at edges 7 and 11.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(2);
    checkOutput("runEntry_notYet", 32'(bus.running), 32'(0));
    waitCycles(1);
    checkOutput("runEntry_running", 32'(bus.running), 32'(1));
    waitCycles(3);
    checkOutput("run_hold96", 32'(countBcd()), 32'(8'h96));
    waitCycles(1);
    checkOutput("run_to98", 32'(countBcd()), 32'(8'h98));
    checkOutput("run_to98_wrap", 32'(bus.wrap), 32'(0));
    waitCycles(3);
    checkOutput("run_hold98", 32'(countBcd()), 32'(8'h98));
    waitCycles(1);
    checkOutput("run_to00", 32'(countBcd()), 32'(8'h00));
    checkOutput("run_to00_wrap", 32'(bus.wrap), 32'(1));
    waitCycles(1);
    checkOutput("run_wrapDrop", 32'(bus.wrap), 32'(0));

    // Clear pulse lands on the edge where the next tick would advance to 02.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput("clearTick_count", 32'(countBcd()), 32'(8'h00));
    checkOutput("clearTick_wrap", 32'(bus.wrap), 32'(0));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(3);
    checkOutput("clearTick_hold", 32'(countBcd()), 32'(8'h00));
    waitCycles(1);
    checkOutput("clearTick_next", 32'(countBcd()), 32'(8'h02));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(3);
    checkOutput("runStepIgnored", 32'(countBcd()), 32'(8'h02));
    waitCycles(1);
    checkOutput("runTickAfterStep", 32'(countBcd()), 32'(8'h04));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    waitCycles(84);
    checkOutput("run_reach46", 32'(countBcd()), 32'(8'h46));
    waitCycles(1);

    reset_n = 1'b0;
    waitCycles(1);
    checkOutput("midReset_count", 32'(countBcd()), 32'(8'h00));
    checkOutput("midReset_running", 32'(bus.running), 32'(0));
    checkOutput("midReset_wrap", 32'(bus.wrap), 32'(0));
    reset_n = 1'b1;
    waitCycles(2);
    checkOutput("reRun_notYet", 32'(bus.running), 32'(0));
    waitCycles(1);
    checkOutput("reRun_running", 32'(bus.running), 32'(1));
    waitCycles(3);
    checkOutput("reRun_hold", 32'(countBcd()), 32'(8'h00));
    waitCycles(1);
    checkOutput("reRun_first", 32'(countBcd()), 32'(8'h02));

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(4);
    checkOutput("backToIdle_running", 32'(bus.running), 32'(0));
    checkOutput("backToIdle_count", 32'(countBcd()), 32'(8'h02));

    // Held button: a single advance on the third edge, nothing afterwards.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("holdStep_edge2", 32'(countBcd()), 32'(8'h02));
    waitCycles(1);
    checkOutput("holdStep_edge3", 32'(countBcd()), 32'(8'h04));
    waitCycles(17);
    checkOutput("holdStep_edge20", 32'(countBcd()), 32'(8'h04));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(3);
    checkOutput("holdStep_release", 32'(countBcd()), 32'(8'h04));

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    waitCycles(2);
    checkOutput("heldReset_inReset", 32'(countBcd()), 32'(8'h00));
    reset_n = 1'b1;
    waitCycles(5);
    checkOutput("heldReset_noPulse", 32'(countBcd()), 32'(8'h00));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(3);
    stepPress(1'b0, 8'h02, 1'b0, "afterHeldReset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/even_bcd_counter.md
EVEN_BCD_COUNTER -- requirements
Module: even_bcd_counter

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clock cycles per automatic count step (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 run_sw  input  1  asynchronous slide switch; 1 = free-run, 0 = hold/manual.
REQ-005 dir_sw  input  1  asynchronous slide switch; 0 = count up, 1 = count down.
REQ-006 step_n  input  1  asynchronous push button, active-low; each press = one manual step.
REQ-007 clear_n  input  1  asynchronous push button, active-low; forces count to 00.
REQ-008 ones  output  4  BCD ones digit; always one of 0,2,4,6,8; feeds the 7-segment decoder.
REQ-009 tens  output  4  BCD tens digit, 0..9; feeds the 7-segment decoder.
REQ-010 wrap  output  1  one-cycle pulse on 98->00 (up) or 00->98 (down) transition.
REQ-011 running  output  1  1 while FSM is in RUN.

Function
REQ-012 Each asynchronous input passes through a two-flop synchronizer; internal logic uses only synchronized values.
REQ-013 step_n and clear_n produce one-cycle press pulses on the synchronized falling edge (1->0); holding generates no further pulses.
REQ-014 FSM states IDLE and RUN; IDLE->RUN when synchronized run_sw=1; RUN->IDLE when synchronized run_sw=0.
REQ-015 Prescaler counts 0..TICK_DIV-1 only in RUN, asserting tick in the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-016 Prescaler is zeroed on every IDLE->RUN transition and while in IDLE; first RUN advance occurs TICK_DIV cycles after entering RUN.
REQ-017 Advance event = tick in RUN, or step pulse in IDLE; step pulses in RUN are ignored.
REQ-018 Up advance: ones+2; if ones=8 then ones=0 and tens+1; if tens=9 and ones=8 then count=00 and wrap=1.
REQ-019 Down advance: ones-2; if ones=0 then ones=8 and tens-1; if count=00 then count=98 and wrap=1.
REQ-020 dir_sw is sampled (synchronized value) in the cycle of each advance event.
REQ-021 clear pulse sets count to 00 next cycle, does not assert wrap, and has priority over a simultaneous advance.
REQ-022 clear does not change FSM state; in RUN it also zeroes the prescaler.
REQ-023 Latency: step_n/clear_n low at a sampling edge -> ones/tens updated 3 clock edges later.
REQ-024 ones/tens/wrap/running are registered outputs; no combinational path from inputs.
REQ-025 Digits never leave legal values: ones in {0,2,4,6,8}, tens in 0..9, in any input sequence.

Reset
REQ-026 While reset_n=0 at a clock edge: ones=0, tens=0, wrap=0, running=0, state=IDLE, prescaler=0, synchronizer flops=1 for step_n/clear_n and 0 for run_sw/dir_sw.
REQ-027 Reset asserted mid-operation (any state, mid-prescale) takes effect at the next edge with no residual pulse after release.
REQ-028 A button held low through reset release produces no press pulse until released and pressed again.

Structure
REQ-029 Shared package even_cnt_pkg holds the state enum typedef (IDLE, RUN), BCD_MAX_ONES=8, BCD_MAX_TENS=9, and the 4-bit BCD digit typedef.
REQ-030 One sub-module, sync_edge: two-flop synchronizer plus falling-edge pulse, instantiated for step_n and clear_n; level switches use synchronizer only.

Verification (TICK_DIV=4)
REQ-031 Reset, run_sw=0, 10 step presses up -> counts 02,04,...,18,20; wrap never asserted.
REQ-032 Preload 96 via steps, run_sw=1, dir up -> 98 then 00 exactly 4 cycles apart, wrap high one cycle on 00.
REQ-033 From 00, dir_sw=1, one step -> 98, wrap pulse; next step -> 96.
REQ-034 RUN with clear_n press landing on tick cycle -> count 00, no wrap, next advance 4 cycles later.
REQ-035 step_n held low 20 cycles in IDLE -> exactly one advance, 3 edges after first low sample.
REQ-036 reset_n low for one cycle mid-RUN at count 46 -> 00, running=0, IDLE; run_sw still 1 -> RUN re-entered, first advance TICK_DIV cycles later.
